// File: rtl/cond_exec_unit_if.sv
// Bundle of ALU-flag, branch, predicated-instruction and status signals
// exchanged between the pipeline and cond_exec_unit.
interface cond_exec_unit_if #(
   parameter int BANK_W = 1,
   parameter int CNT_W  = 16
);
   logic [3:0]        flags_in;
   logic              flag_we;
   logic [BANK_W-1:0] flag_wbank;
   logic              br_valid;
   logic [3:0]        br_cond;
   logic [BANK_W-1:0] br_bank;
   logic              ex_valid;
   logic [3:0]        ex_cond;
   logic [BANK_W-1:0] ex_bank;
   logic              pc_src;
   logic              ex_en;
   logic              flush;
   logic [3:0]        flags_out;
   logic [CNT_W-1:0]  br_taken_cnt;

   modport master (
      output flags_in, flag_we, flag_wbank, br_valid, br_cond, br_bank,
             ex_valid, ex_cond, ex_bank,
      input  pc_src, ex_en, flush, flags_out, br_taken_cnt
   );

   modport slave (
      input  flags_in, flag_we, flag_wbank, br_valid, br_cond, br_bank,
             ex_valid, ex_cond, ex_bank,
      output pc_src, ex_en, flush, flags_out, br_taken_cnt
   );
endinterface

// File: rtl/cond_exec_unit.sv
// Banked NZCV flags, ARM condition evaluation for one branch and one
// predicated instruction per cycle, post-branch flush sequencer.
//
// state | meaning
// IDLE  | accepting branches, predicated ops and flag writes
// FLUSH | squashing younger stages; all inputs ignored
module cond_exec_unit #(
   parameter int NBANKS       = 2,
   parameter int BYPASS       = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16,
   parameter int BANK_W       = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
   input logic             clk,
   input logic             rst_n,
   cond_exec_unit_if.slave bus
);
   localparam int              CW       = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam logic [CW-1:0]   CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;
   localparam logic [BANK_W:0] NB       = (BANK_W + 1)'(NBANKS);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    fcnt_q, fcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bank_q [NBANKS];
   logic [3:0]       bank_d [NBANKS];

   logic       idle;
   logic [3:0] br_f, ex_f;
   logic       pc_src, ex_en;

   function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v, r;
      {n, z, c, v} = f;
      case (cc)
         4'h0:    r = z;
         4'h1:    r = !z;
         4'h2:    r = c;
         4'h3:    r = !c;
         4'h4:    r = n;
         4'h5:    r = !n;
         4'h6:    r = v;
         4'h7:    r = !v;
         4'h8:    r = c & !z;
         4'h9:    r = !c | z;
         4'hA:    r = (n == v);
         4'hB:    r = (n != v);
         4'hC:    r = !z & (n == v);
         4'hD:    r = z | (n != v);
         4'hE:    r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   assign idle = (state_q == IDLE);

   // Readers of a nonexistent bank see all-zero flags, bypass included.
   always_comb begin
      br_f = 4'b0000;
      ex_f = 4'b0000;
      if ({1'b0, bus.br_bank} < NB) begin
         if (BYPASS != 0 && bus.flag_we && bus.flag_wbank == bus.br_bank)
            br_f = bus.flags_in;
         else
            br_f = bank_q[bus.br_bank];
      end
      if ({1'b0, bus.ex_bank} < NB) begin
         if (BYPASS != 0 && bus.flag_we && bus.flag_wbank == bus.ex_bank)
            ex_f = bus.flags_in;
         else
            ex_f = bank_q[bus.ex_bank];
      end
   end

   assign pc_src = bus.br_valid & cond_eval(bus.br_cond, br_f) & idle;
   assign ex_en  = bus.ex_valid & cond_eval(bus.ex_cond, ex_f) & idle;

   // The flag write belongs to an older instruction, so it commits even
   // when a branch in the same cycle is taken.
   always_comb begin
      bank_d = bank_q;
      if (idle && bus.flag_we && ({1'b0, bus.flag_wbank} < NB))
         bank_d[bus.flag_wbank] = bus.flags_in;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (pc_src && cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         IDLE: begin
            if (pc_src && FLUSH_CYCLES > 0) begin
               state_d = FLUSH;
               fcnt_d  = CNT_LOAD;
            end
         end
         FLUSH: begin
            if (fcnt_q == '0)
               state_d = IDLE;
            else
               fcnt_d = fcnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         fcnt_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < NBANKS; i++)
            bank_q[i] <= 4'b0000;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
      end
   end

   assign bus.pc_src       = pc_src;
   assign bus.ex_en        = ex_en;
   assign bus.flush        = (state_q == FLUSH);
   assign bus.flags_out    = bank_q[0];
   assign bus.br_taken_cnt = cnt_q;
endmodule

// File: tb/tb_cond_exec_unit.sv
// Self-checking bench for cond_exec_unit: directed vector table, hand-written
// flush/reset/saturation sequences, and random traffic against a flag model.
module tb_cond_exec_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;

   cond_exec_unit_if #(.BANK_W(1), .CNT_W(16)) if_a ();
   cond_exec_unit_if #(.BANK_W(1), .CNT_W(16)) if_b ();
   cond_exec_unit_if #(.BANK_W(2), .CNT_W(2))  if_c ();

   cond_exec_unit #(.NBANKS(2), .BYPASS(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_a), .bus(if_a));
   cond_exec_unit #(.NBANKS(2), .BYPASS(0), .FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_b), .bus(if_b));
   cond_exec_unit #(.NBANKS(3), .BYPASS(1), .FLUSH_CYCLES(0), .CNT_W(2)) dut_c (
      .clk(clk), .rst_n(rst_c), .bus(if_c));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference condition: even codes are base predicates, odd codes invert them.
   function automatic logic m_cond(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return base ^ cc[0];
   endfunction

   task automatic drive_a(input logic we, input logic [3:0] fin, input logic wb,
                          input logic bv, input logic [3:0] bc, input logic bb,
                          input logic ev, input logic [3:0] ec, input logic eb);
      if_a.flag_we = we; if_a.flags_in = fin; if_a.flag_wbank = wb;
      if_a.br_valid = bv; if_a.br_cond = bc; if_a.br_bank = bb;
      if_a.ex_valid = ev; if_a.ex_cond = ec; if_a.ex_bank = eb;
   endtask

   task automatic drive_b(input logic we, input logic [3:0] fin, input logic wb,
                          input logic bv, input logic [3:0] bc, input logic bb);
      if_b.flag_we = we; if_b.flags_in = fin; if_b.flag_wbank = wb;
      if_b.br_valid = bv; if_b.br_cond = bc; if_b.br_bank = bb;
      if_b.ex_valid = 1'b0; if_b.ex_cond = 4'h0; if_b.ex_bank = 1'b0;
   endtask

   task automatic drive_c(input logic we, input logic [3:0] fin, input logic [1:0] wb,
                          input logic bv, input logic [3:0] bc, input logic [1:0] bb,
                          input logic ev, input logic [3:0] ec, input logic [1:0] eb);
      if_c.flag_we = we; if_c.flags_in = fin; if_c.flag_wbank = wb;
      if_c.br_valid = bv; if_c.br_cond = bc; if_c.br_bank = bb;
      if_c.ex_valid = ev; if_c.ex_cond = ec; if_c.ex_bank = eb;
   endtask

   typedef struct {
      logic       we;  logic [3:0] fin; logic wb;
      logic       bv;  logic [3:0] bc;  logic bb;
      logic       ev;  logic [3:0] ec;  logic eb;
      logic       pc;  logic en; logic fl; logic [3:0] fo; int cnt;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [3:0] fin, input logic wb,
                               input logic bv, input logic [3:0] bc, input logic bb,
                               input logic ev, input logic [3:0] ec, input logic eb,
                               input logic pc, input logic en, input logic fl,
                               input logic [3:0] fo, input int cnt);
      vec_t r;
      r.we = we; r.fin = fin; r.wb = wb; r.bv = bv; r.bc = bc; r.bb = bb;
      r.ev = ev; r.ec = ec; r.eb = eb; r.pc = pc; r.en = en; r.fl = fl;
      r.fo = fo; r.cnt = cnt;
      return r;
   endfunction

   vec_t tbl [17];

   logic [3:0] ma_fl [2];
   int         ma_left, ma_cnt;
   logic [3:0] mc_fl [3];
   int         mc_cnt;

   initial begin
      // One row per cycle on dut_a; outputs are sampled before the edge.
      tbl[0]  = mk(0, 4'h0, 0, 1, 4'hE, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 0);
      tbl[1]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 1);
      tbl[2]  = mk(1, 4'hF, 0, 1, 4'hE, 0, 1, 4'hE, 0, 0, 0, 1, 4'h0, 1);
      tbl[3]  = mk(0, 4'h0, 0, 1, 4'h1, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1);
      tbl[4]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 2);
      tbl[5]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 2);
      tbl[6]  = mk(0, 4'h0, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 2);
      tbl[7]  = mk(1, 4'h4, 1, 1, 4'h0, 1, 0, 4'h0, 0, 1, 0, 0, 4'h0, 2);
      tbl[8]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 3);
      tbl[9]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'hE, 0, 0, 0, 1, 4'h0, 3);
      tbl[10] = mk(0, 4'h0, 0, 1, 4'h0, 1, 1, 4'h0, 0, 1, 0, 0, 4'h0, 3);
      tbl[11] = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 4);
      tbl[12] = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 4);
      tbl[13] = mk(1, 4'h8, 0, 1, 4'hE, 0, 1, 4'h4, 0, 1, 1, 0, 4'h0, 4);
      tbl[14] = mk(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h4, 0, 0, 0, 1, 4'h8, 5);
      tbl[15] = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h8, 5);
      tbl[16] = mk(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h4, 0, 0, 1, 0, 4'h8, 5);

      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      drive_a(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
      drive_b(0, 4'h0, 0, 0, 4'h0, 0);
      drive_c(0, 4'h0, 2'd0, 0, 4'h0, 2'd0, 0, 4'h0, 2'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_flush", 32'(if_a.flush), 32'd0);
      chk("rst_flags_out", 32'(if_a.flags_out), 32'd0);
      chk("rst_cnt", 32'(if_a.br_taken_cnt), 32'd0);
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Directed table on dut_a
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive_a(tbl[i].we, tbl[i].fin, tbl[i].wb, tbl[i].bv, tbl[i].bc, tbl[i].bb,
                 tbl[i].ev, tbl[i].ec, tbl[i].eb);
         #1;
         chk($sformatf("tbl%0d_pc_src", i), 32'(if_a.pc_src), 32'(tbl[i].pc));
         chk($sformatf("tbl%0d_ex_en", i), 32'(if_a.ex_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_flush", i), 32'(if_a.flush), 32'(tbl[i].fl));
         chk($sformatf("tbl%0d_flags_out", i), 32'(if_a.flags_out), 32'(tbl[i].fo));
         chk($sformatf("tbl%0d_cnt", i), 32'(if_a.br_taken_cnt), 32'(tbl[i].cnt));
      end

      // 16 conditions x 16 NZCV values written to bank 0; bank 1 still holds Z.
      for (int nz = 0; nz < 16; nz++) begin
         @(negedge clk);
         drive_a(1, 4'(nz), 0, 0, 4'h0, 0, 0, 4'h0, 0);
         for (int cc = 0; cc < 16; cc++) begin
            @(negedge clk);
            drive_a(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'(cc), 0);
            #1;
            chk($sformatf("sweep_nzcv%0h_cc%0h", nz, cc), 32'(if_a.ex_en),
                32'(m_cond(4'(cc), 4'(nz))));
         end
         @(negedge clk);
         drive_a(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h0, 1);
         #1;
         chk($sformatf("sweep_bank1_eq_%0h", nz), 32'(if_a.ex_en), 32'd1);
         chk($sformatf("sweep_flags_out_%0h", nz), 32'(if_a.flags_out), 32'(nz));
      end

      // Reset in the first flush cycle
      @(negedge clk);
      drive_a(0, 4'h0, 0, 1, 4'hE, 0, 0, 4'h0, 0);
      #1 chk("midrst_pc_src", 32'(if_a.pc_src), 32'd1);
      @(negedge clk);
      drive_a(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
      #1 chk("midrst_flush_before", 32'(if_a.flush), 32'd1);
      rst_a = 1'b0;
      #1;
      chk("midrst_flush_after", 32'(if_a.flush), 32'd0);
      chk("midrst_flags_out", 32'(if_a.flags_out), 32'd0);
      chk("midrst_cnt", 32'(if_a.br_taken_cnt), 32'd0);
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      #1 chk("postrst_no_flush", 32'(if_a.flush), 32'd0);
      drive_a(0, 4'h0, 0, 1, 4'hE, 0, 0, 4'h0, 0);
      #1 chk("postrst_pc_src", 32'(if_a.pc_src), 32'd1);
      @(negedge clk);
      drive_a(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
      #1;
      chk("postrst_cnt", 32'(if_a.br_taken_cnt), 32'd1);
      chk("postrst_flush", 32'(if_a.flush), 32'd1);

      // dut_b: no bypass
      @(negedge clk); drive_b(0, 4'h0, 0, 1, 4'hF, 0);
      #1 chk("b_nv", 32'(if_b.pc_src), 32'd0);
      @(negedge clk); drive_b(0, 4'h0, 0, 1, 4'h0, 0);
      #1 chk("b_eq_zero_flags", 32'(if_b.pc_src), 32'd0);
      @(negedge clk); drive_b(0, 4'h0, 0, 1, 4'hE, 0);
      #1 chk("b_al", 32'(if_b.pc_src), 32'd1);
      @(negedge clk); drive_b(0, 4'h0, 0, 0, 4'h0, 0);
      #1;
      chk("b_cnt_after_al", 32'(if_b.br_taken_cnt), 32'd1);
      chk("b_flush1", 32'(if_b.flush), 32'd1);
      @(negedge clk);
      #1 chk("b_flush2", 32'(if_b.flush), 32'd1);
      @(negedge clk);
      #1 chk("b_flush_done", 32'(if_b.flush), 32'd0);
      drive_b(1, 4'h4, 1, 1, 4'h0, 1);
      #1 chk("b_nobypass_same_cycle", 32'(if_b.pc_src), 32'd0);
      @(negedge clk); drive_b(0, 4'h0, 0, 1, 4'h0, 1);
      #1;
      chk("b_nobypass_next_cycle", 32'(if_b.pc_src), 32'd1);
      chk("b_bank0_untouched", 32'(if_b.flags_out), 32'd0);
      @(negedge clk); drive_b(0, 4'h0, 0, 0, 4'h0, 0);

      // dut_c: CNT_W=2 saturation without flush
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive_c(0, 4'h0, 2'd0, 1, 4'hE, 2'd0, 0, 4'h0, 2'd0);
         #1 chk($sformatf("c_sat_pc%0d", k), 32'(if_c.pc_src), 32'd1);
         @(posedge clk);
         #1;
         chk($sformatf("c_sat_cnt%0d", k), 32'(if_c.br_taken_cnt), 32'((k < 3) ? k + 1 : 3));
         chk($sformatf("c_no_flush%0d", k), 32'(if_c.flush), 32'd0);
      end
      @(negedge clk);
      drive_c(1, 4'h4, 2'd3, 1, 4'h0, 2'd3, 1, 4'h1, 2'd3);
      #1;
      chk("c_oob_eq", 32'(if_c.pc_src), 32'd0);
      chk("c_oob_ne", 32'(if_c.ex_en), 32'd1);
      @(negedge clk);
      drive_c(0, 4'h0, 2'd0, 1, 4'h0, 2'd3, 1, 4'h0, 2'd0);
      #1;
      chk("c_oob_after_write", 32'(if_c.pc_src), 32'd0);
      chk("c_bank0_eq", 32'(if_c.ex_en), 32'd0);

      // Random traffic on dut_a and dut_c from a fresh reset
      @(negedge clk);
      drive_a(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
      drive_c(0, 4'h0, 2'd0, 0, 4'h0, 2'd0, 0, 4'h0, 2'd0);
      rst_a = 1'b0; rst_c = 1'b0;
      @(negedge clk);
      rst_a = 1'b1; rst_c = 1'b1;
      ma_fl[0] = 4'h0; ma_fl[1] = 4'h0; ma_left = 0; ma_cnt = 0;
      for (int i = 0; i < 3; i++) mc_fl[i] = 4'h0;
      mc_cnt = 0;
      for (int t = 0; t < 400; t++) begin
         logic       a_we, a_wb, a_bv, a_bb, a_ev, a_eb, e_pc, e_en, busy;
         logic [3:0] a_fin, a_bc, a_ec, fb, fe;
         logic       c_we, c_bv, c_ev, ce_pc, ce_en;
         logic [1:0] c_wb, c_bb, c_eb;
         logic [3:0] c_fin, c_bc, c_ec, cb, ce;
         @(negedge clk);
         a_we = 1'($urandom_range(0, 1)); a_fin = 4'($urandom); a_wb = 1'($urandom);
         a_bv = ($urandom_range(0, 2) != 0); a_bc = 4'($urandom); a_bb = 1'($urandom);
         a_ev = 1'($urandom); a_ec = 4'($urandom); a_eb = 1'($urandom);
         c_we = 1'($urandom); c_fin = 4'($urandom); c_wb = 2'($urandom);
         c_bv = 1'($urandom); c_bc = 4'($urandom); c_bb = 2'($urandom);
         c_ev = 1'($urandom); c_ec = 4'($urandom); c_eb = 2'($urandom);
         drive_a(a_we, a_fin, a_wb, a_bv, a_bc, a_bb, a_ev, a_ec, a_eb);
         drive_c(c_we, c_fin, c_wb, c_bv, c_bc, c_bb, c_ev, c_ec, c_eb);

         busy = (ma_left > 0);
         fb = (a_we && a_wb == a_bb) ? a_fin : ma_fl[a_bb];
         fe = (a_we && a_wb == a_eb) ? a_fin : ma_fl[a_eb];
         e_pc = !busy && a_bv && m_cond(a_bc, fb);
         e_en = !busy && a_ev && m_cond(a_ec, fe);

         cb = (c_bb == 2'd3) ? 4'h0 : ((c_we && c_wb == c_bb) ? c_fin : mc_fl[c_bb]);
         ce = (c_eb == 2'd3) ? 4'h0 : ((c_we && c_wb == c_eb) ? c_fin : mc_fl[c_eb]);
         ce_pc = c_bv && m_cond(c_bc, cb);
         ce_en = c_ev && m_cond(c_ec, ce);

         #1;
         chk($sformatf("rnd%0d_a_pc_src", t), 32'(if_a.pc_src), 32'(e_pc));
         chk($sformatf("rnd%0d_a_ex_en", t), 32'(if_a.ex_en), 32'(e_en));
         chk($sformatf("rnd%0d_a_flush", t), 32'(if_a.flush), 32'(busy));
         chk($sformatf("rnd%0d_a_flags_out", t), 32'(if_a.flags_out), 32'(ma_fl[0]));
         chk($sformatf("rnd%0d_a_cnt", t), 32'(if_a.br_taken_cnt), 32'(ma_cnt));
         chk($sformatf("rnd%0d_c_pc_src", t), 32'(if_c.pc_src), 32'(ce_pc));
         chk($sformatf("rnd%0d_c_ex_en", t), 32'(if_c.ex_en), 32'(ce_en));
         chk($sformatf("rnd%0d_c_flags_out", t), 32'(if_c.flags_out), 32'(mc_fl[0]));
         chk($sformatf("rnd%0d_c_cnt", t), 32'(if_c.br_taken_cnt), 32'(mc_cnt));

         if (busy) ma_left--;
         else begin
            if (a_we) ma_fl[a_wb] = a_fin;
            if (e_pc) begin
               ma_cnt++;
               ma_left = 2;
            end
         end
         if (c_we && c_wb != 2'd3) mc_fl[c_wb] = c_fin;
         if (ce_pc && mc_cnt < 3) mc_cnt++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
